fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//   Decoupling instruction queue between if_stage and the ID stage. It captures each
//   buffered fetch word (inst, PC) presented by if_stage and holds it in a DEPTH-entry FIFO.
//   It stalls IF only when full, presents the oldest entry to ID with a valid/ready handshake,
//   predecodes control-flow opcodes, and empties completely on a redirect flush.
// PARAMETERS
//   DEPTH    4             number of entries; power of two, >= 2
//   NOP_INST 32'h00000013  instruction word driven on o_id_inst while the queue is empty
// PORTS
//   i_clk           in   1                  clock, rising edge
//   i_rst_n         in   1                  asynchronous active-low reset
//   i_inst_valid    in   1                  IF holds a fetched word (if_stage o_inst_valid)
//   i_inst          in   32                 fetched instruction word
//   i_fetch_pc      in   32                 PC of i_inst
//   o_stall_if      out  1                  to if_stage i_stall_pc; word not accepted this cycle
//   i_flush         in   1                  redirect/flush (same pulse as IF i_pc_redirect)
//   o_id_valid      out  1                  head entry valid
//   o_id_inst       out  32                 head instruction word
//   o_id_pc         out  32                 head PC
//   o_id_pc_plus_4  out  32                 head PC + 4, modulo 2^32
//   o_id_is_ctrl    out  1                  head opcode[6:0] is 1101111, 1100111 or 1100011
//   i_id_ready      in   1                  ID consumes the head this cycle
//   o_count         out  $clog2(DEPTH)+1    current occupancy, 0..DEPTH
// BEHAVIOUR
//   - Reset (async, i_rst_n=0):
//       - rd_ptr, wr_ptr and count clear to 0.
//       - Outputs: o_id_valid=0, o_stall_if=0, o_count=0, o_id_inst=NOP_INST, o_id_pc=0,
//         o_id_pc_plus_4=4, o_id_is_ctrl=0.
//       - Reset mid-operation discards all entries.
//       - Storage array is not reset.
//   - Definitions:
//       - full = (count==DEPTH); empty = (count==0).
//       - push = i_inst_valid & ~full & ~i_flush.
//       - pop  = o_id_valid & i_id_ready & ~i_flush.
//   - o_stall_if = full:
//       - Driven from registers only; no combinational path from i_id_ready.
//       - When full and popping, the push is still refused that cycle. It is accepted the next cycle.
//   - IF handshake:
//       - IF holds a word while o_stall_if=1.
//       - IF drops valid in the cycle o_stall_if=0, so each word pushes exactly once.
//   - Push: write {inst, pc, is_ctrl} at wr_ptr; wr_ptr += 1 mod DEPTH.
//   - Pop: rd_ptr += 1 mod DEPTH.
//   - Count: +1 on push only, -1 on pop only, unchanged on push & pop.
//   - Latency:
//       - A word pushed at edge N is visible at the head after edge N if the queue was empty.
//       - There is no same-cycle bypass.
//   - Head outputs: combinational read of entry rd_ptr; o_id_valid = ~empty.
//       - When empty, drive NOP_INST / pc 0 / pc+4 = 4 / is_ctrl 0.
//   - Flush:
//       - Next edge: count=0, rd_ptr=wr_ptr=0.
//       - Any push or pop in the flush cycle is ignored.
//       - o_id_valid=0 and o_stall_if=0 from the following cycle.
//       - Flush while empty is a no-op.
//       - Flush has priority over push and pop.
//   - Pointer wrap:
//       - Pointers are $clog2(DEPTH) bits and wrap naturally.
//       - The full/empty distinction comes from count, never from pointer equality.
//   - is_ctrl: computed from i_inst[6:0] at push and stored per entry.
// TESTING
//   - Reset, then push 0x00000013@0x0, 0x0080006F@0x4 with i_id_ready=0
//       -> o_count=2, head pc=0x0, is_ctrl=0.
//     Then pop one -> head inst=0x0080006F, pc=0x4, pc_plus_4=0x8, is_ctrl=1.
//   - DEPTH=4, fill 4 words with ready=0 -> o_stall_if=1, o_count=4.
//     A 5th word is held by IF and pushed the cycle after ready=1.
//     Pop order is 0x0,0x4,0x8,0xC,0x10.
//   - Stream 10 words with ready=1 each cycle -> pointers wrap, PC order is preserved,
//     o_count stays <=1, and o_stall_if never asserts.
//   - Count=3, flush together with i_inst_valid=1 and i_id_ready=1
//       -> next cycle o_count=0, o_id_valid=0, o_id_inst=0x00000013.
//     The flush-cycle word is not stored.
//   - i_fetch_pc=0xFFFFFFFC pushed -> o_id_pc_plus_4=0x00000000.
//   - Deassert i_rst_n asynchronously with 2 entries held
//       -> outputs return to reset values before the next clock edge.

Source files
------------

// File: rtl/fetch_queue.sv
// Decoupling queue between the fetch and decode stages: holds fetched (inst, pc) pairs,
// presents the oldest to decode via valid/ready, predecodes control-flow opcodes.
module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] NOP_INST = 32'h00000013
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_inst_valid,
   input  logic [31:0]                i_inst,
   input  logic [31:0]                i_fetch_pc,
   output logic                       o_stall_if,
   input  logic                       i_flush,
   output logic                       o_id_valid,
   output logic [31:0]                o_id_inst,
   output logic [31:0]                o_id_pc,
   output logic [31:0]                o_id_pc_plus_4,
   output logic                       o_id_is_ctrl,
   input  logic                       i_id_ready,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   localparam logic [PW-1:0] PtrOne   = PW'(1);
   localparam logic [CW-1:0] CntOne   = CW'(1);
   localparam logic [CW-1:0] CntDepth = CW'(DEPTH);

   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpBranch = 7'b1100011;

   logic [31:0] inst_mem [DEPTH];
   logic [31:0] pc_mem   [DEPTH];
   logic        ctrl_mem [DEPTH];

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic full, empty, push, pop;
   logic in_is_ctrl;

   // Occupancy alone tells full from empty; pointers may be equal in both cases.
   assign full  = (count_q == CntDepth);
   assign empty = (count_q == '0);

   assign push = i_inst_valid & ~full & ~i_flush;
   assign pop  = ~empty & i_id_ready & ~i_flush;

   assign in_is_ctrl = (i_inst[6:0] == OpJal) || (i_inst[6:0] == OpJalr) ||
                       (i_inst[6:0] == OpBranch);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (i_flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
         end
         if (push && !pop) begin
            count_d = count_q + CntOne;
         end else if (pop && !push) begin
            count_d = count_q - CntOne;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage is deliberately left unreset; validity comes from count.
   always_ff @(posedge i_clk) begin
      if (push) begin
         inst_mem[wr_ptr_q] <= i_inst;
         pc_mem[wr_ptr_q]   <= i_fetch_pc;
         ctrl_mem[wr_ptr_q] <= in_is_ctrl;
      end
   end

   always_comb begin
      o_id_inst    = NOP_INST;
      o_id_pc      = '0;
      o_id_is_ctrl = 1'b0;
      if (!empty) begin
         o_id_inst    = inst_mem[rd_ptr_q];
         o_id_pc      = pc_mem[rd_ptr_q];
         o_id_is_ctrl = ctrl_mem[rd_ptr_q];
      end
   end

   assign o_id_pc_plus_4 = o_id_pc + 32'd4;
   assign o_id_valid     = ~empty;
   assign o_stall_if     = full;
   assign o_count        = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: words are queued when driven and compared at the head.
module tb_fetch_queue;

   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h00000013;

   typedef struct {
      logic [31:0] w;
      logic [31:0] p;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        inst_valid = 1'b0;
   logic [31:0] inst = '0;
   logic [31:0] fetch_pc = '0;
   logic        stall_if;
   logic        flush = 1'b0;
   logic        id_valid;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus_4;
   logic        id_is_ctrl;
   logic        id_ready = 1'b0;
   logic [2:0]  count;

   int   checks = 0;
   int   errors = 0;
   ent_t sb[$];

   fetch_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_inst_valid   (inst_valid),
      .i_inst         (inst),
      .i_fetch_pc     (fetch_pc),
      .o_stall_if     (stall_if),
      .i_flush        (flush),
      .o_id_valid     (id_valid),
      .o_id_inst      (id_inst),
      .o_id_pc        (id_pc),
      .o_id_pc_plus_4 (id_pc_plus_4),
      .o_id_is_ctrl   (id_is_ctrl),
      .i_id_ready     (id_ready),
      .o_count        (count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   function automatic logic ref_ctrl(input logic [31:0] w);
      return (w[6:0] == 7'h6F) || (w[6:0] == 7'h67) || (w[6:0] == 7'h63);
   endfunction

   // Drive one cycle; update the scoreboard from the bench's own queue model.
   task automatic tick(input logic v, input logic [31:0] w, input logic [31:0] p,
                       input logic rdy, input logic fl);
      bit do_push, do_pop;
      inst_valid = v; inst = w; fetch_pc = p; id_ready = rdy; flush = fl;
      do_push = v && (sb.size() < DEPTH) && !fl;
      do_pop  = (sb.size() > 0) && rdy && !fl;
      @(posedge clk);
      #1;
      if (fl) sb.delete();
      else begin
         if (do_pop) sb.delete(0);
         if (do_push) sb.push_back('{w: w, p: p});
      end
      inst_valid = 1'b0; id_ready = 1'b0; flush = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", id_valid); end
      checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b want 0", stall_if); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", count); end
      checks++; if (id_inst !== NOP) begin errors++; $display("FAIL rst_inst got %h want %h", id_inst, NOP); end
      checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", id_pc); end
      checks++; if (id_pc_plus_4 !== 32'h4) begin errors++; $display("FAIL rst_pc4 got %h want 4", id_pc_plus_4); end
      checks++; if (id_is_ctrl !== 1'b0) begin errors++; $display("FAIL rst_ctrl got %0b want 0", id_is_ctrl); end
      rst_n = 1'b1;
      sb.delete();
   endtask

   task automatic test_basic();
      tick(1'b1, 32'h00000013, 32'h0, 1'b0, 1'b0);
      tick(1'b1, 32'h0080006F, 32'h4, 1'b0, 1'b0);
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL basic_count got %0d want 2", count); end
      checks++; if (id_pc !== sb[0].p) begin errors++; $display("FAIL basic_pc0 got %h want %h", id_pc, sb[0].p); end
      checks++; if (id_inst !== sb[0].w) begin errors++; $display("FAIL basic_inst0 got %h want %h", id_inst, sb[0].w); end
      checks++; if (id_is_ctrl !== 1'b0) begin errors++; $display("FAIL basic_ctrl0 got %0b want 0", id_is_ctrl); end
      tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checks++; if (id_inst !== 32'h0080006F) begin errors++; $display("FAIL basic_inst1 got %h want 0080006f", id_inst); end
      checks++; if (id_pc !== 32'h4) begin errors++; $display("FAIL basic_pc1 got %h want 4", id_pc); end
      checks++; if (id_pc_plus_4 !== 32'h8) begin errors++; $display("FAIL basic_pc4 got %h want 8", id_pc_plus_4); end
      checks++; if (id_is_ctrl !== 1'b1) begin errors++; $display("FAIL basic_ctrl1 got %0b want 1", id_is_ctrl); end
      tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL basic_empty got %0b want 0", id_valid); end
   endtask

   task automatic test_full();
      for (int i = 0; i < 4; i++) tick(1'b1, 32'h00000013 + (i << 20), i * 4, 1'b0, 1'b0);
      checks++; if (stall_if !== 1'b1) begin errors++; $display("FAIL full_stall got %0b want 1", stall_if); end
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", count); end
      // Fifth word offered while popping from full: refused this cycle.
      tick(1'b1, 32'h00400013, 32'h10, 1'b1, 1'b0);
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_refuse got %0d want 3", count); end
      checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL full_unstall got %0b want 0", stall_if); end
      tick(1'b1, 32'h00400013, 32'h10, 1'b0, 1'b0);
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_accept got %0d want 4", count); end
      for (int i = 1; i < 5; i++) begin
         checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL full_valid%0d got %0b want 1", i, id_valid); end
         checks++; if (id_pc !== 32'(i * 4)) begin errors++; $display("FAIL full_order%0d got %h want %h", i, id_pc, i * 4); end
         checks++; if (id_inst !== sb[0].w) begin errors++; $display("FAIL full_inst%0d got %h want %h", i, id_inst, sb[0].w); end
         tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL full_drain got %0d want 0", count); end
   endtask

   task automatic test_stream();
      logic [31:0] w;
      int npop = 0;
      for (int i = 0; i <= 10; i++) begin
         checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL stream_stall%0d got %0b want 0", i, stall_if); end
         checks++; if (count > 3'd1) begin errors++; $display("FAIL stream_count%0d got %0d want <=1", i, count); end
         if (sb.size() > 0) begin
            checks++; if (id_pc !== 32'h100 + 32'(npop * 4)) begin errors++; $display("FAIL stream_pc%0d got %h want %h", npop, id_pc, 32'h100 + npop * 4); end
            checks++; if (id_inst !== sb[0].w) begin errors++; $display("FAIL stream_inst%0d got %h want %h", npop, id_inst, sb[0].w); end
            checks++; if (id_is_ctrl !== ref_ctrl(sb[0].w)) begin errors++; $display("FAIL stream_ctrl%0d got %0b want %0b", npop, id_is_ctrl, ref_ctrl(sb[0].w)); end
            npop++;
         end
         w = (i % 2 == 0) ? 32'h00000013 + (i << 20) : 32'h00000063 + (i << 20);
         tick(i < 10, w, 32'h100 + 32'(i * 4), 1'b1, 1'b0);
      end
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL stream_end got %0b want 0", id_valid); end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) tick(1'b1, 32'h00000013 + (i << 20), 32'h200 + 32'(i * 4), 1'b0, 1'b0);
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre got %0d want 3", count); end
      tick(1'b1, 32'h0000006F, 32'h300, 1'b1, 1'b1);
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d want 0", count); end
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", id_valid); end
      checks++; if (id_inst !== NOP) begin errors++; $display("FAIL flush_inst got %h want %h", id_inst, NOP); end
      checks++; if (stall_if !== 1'b0) begin errors++; $display("FAIL flush_stall got %0b want 0", stall_if); end
      tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_nostore got %0d want 0", count); end
      tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got %0b want 0", id_valid); end
      tick(1'b1, 32'h00000067, 32'h400, 1'b0, 1'b0);
      checks++; if (id_pc !== 32'h400) begin errors++; $display("FAIL flush_after got %h want 400", id_pc); end
      tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
   endtask

   task automatic test_pc_wrap();
      tick(1'b1, 32'h00008067, 32'hFFFFFFFC, 1'b0, 1'b0);
      tick(1'b1, 32'h00000063, 32'h0, 1'b0, 1'b0);
      checks++; if (id_pc_plus_4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got %h want 0", id_pc_plus_4); end
      checks++; if (id_is_ctrl !== 1'b1) begin errors++; $display("FAIL wrap_jalr got %0b want 1", id_is_ctrl); end
      tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checks++; if (id_is_ctrl !== 1'b1) begin errors++; $display("FAIL wrap_branch got %0b want 1", id_is_ctrl); end
      checks++; if (id_pc_plus_4 !== 32'h4) begin errors++; $display("FAIL wrap_pc4b got %h want 4", id_pc_plus_4); end
      tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
   endtask

   task automatic test_async_reset();
      tick(1'b1, 32'h0000006F, 32'h500, 1'b0, 1'b0);
      tick(1'b1, 32'h00000013, 32'h504, 1'b0, 1'b0);
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL arst_pre got %0d want 2", count); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %0b want 0", id_valid); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL arst_count got %0d want 0", count); end
      checks++; if (id_inst !== NOP) begin errors++; $display("FAIL arst_inst got %h want %h", id_inst, NOP); end
      checks++; if (id_pc_plus_4 !== 32'h4) begin errors++; $display("FAIL arst_pc4 got %h want 4", id_pc_plus_4); end
      checks++; if (id_is_ctrl !== 1'b0) begin errors++; $display("FAIL arst_ctrl got %0b want 0", id_is_ctrl); end
      sb.delete();
      #1 rst_n = 1'b1;
      tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL arst_post got %0b want 0", id_valid); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_stream();
      test_flush();
      test_pc_wrap();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
